hcal_multi_serializer: RTL
==========================

// Module: hcal_multi_serializer
// PURPOSE
//   Multi-channel parallel-to-serial converter for the HCAL front-end data path; next generation of the
//   single-channel shifter. Adds parametrised width and channel count, a valid/ready load handshake,
//   a double buffer for gap-free back-to-back frames, selectable bit order, frame marker and underrun flag.
//   Sits between the front-end word builder (parallel side) and the per-channel link drivers (serial side).
// PARAMETERS
//   WIDTH      16  bits per channel per frame; legal range 2..64
//   CHANNELS   4   independent serial lanes, all loaded together as one word; legal range 1..16
//   LSB_FIRST  1   1: bit 0 is sent first; 0: bit WIDTH-1 is sent first
//   IDLE_BIT   0   level driven on every lane while no frame is being sent
// PORTS
//   clk          in   1               single rising-edge clock; no negedge logic anywhere in the block
//   reset        in   1               asynchronous, active-high
//   load_valid   in   1               load_data is valid
//   load_ready   out  1               holding buffer is empty; transfer occurs when valid && ready
//   load_data    in   CHANNELS*WIDTH  lane c word = load_data[c*WIDTH +: WIDTH]
//   serial_out   out  CHANNELS        registered serial bit per lane
//   frame_start  out  1               registered; high during the cycle the first bit of a frame is on serial_out
//   busy         out  1               registered; high while a frame bit is on serial_out
//   underrun     out  1               registered 1-cycle pulse when a frame ends with no next frame buffered
//   frame_count  out  16              frames started since reset; wraps 0xFFFF -> 0x0000
// BEHAVIOUR
//   Reset values: serial_out = {CHANNELS{IDLE_BIT}}, frame_start = 0, busy = 0, underrun = 0,
//     frame_count = 0, hold buffer empty (load_ready = 1), state IDLE, bit counter 0.
//   load_ready = !hold_full (no combinational path from load_valid). An accepted word goes to the hold buffer.
//   State IDLE: on an edge with hold_full set -> move hold to shifter, clear hold_full, load bit 0 of the
//     frame into serial_out, frame_start = 1, busy = 1, frame_count += 1, go SHIFT with bit counter 1.
//   Latency: word accepted at edge N while IDLE -> first bit on serial_out after edge N+1.
//   State SHIFT: each edge outputs the next bit; frame_start = 0 after the first bit.
//   Bit k of the frame (k = 0..WIDTH-1) is held on serial_out for exactly one cycle. It is word bit k
//     when LSB_FIRST = 1, and word bit WIDTH-1-k when LSB_FIRST = 0.
//   Frame end, at the edge after bit WIDTH-1 is output:
//     - hold_full: start the next frame on that same edge (same actions as IDLE start). There is no gap,
//       and frame_start pulses again.
//     - hold empty: serial_out = IDLE_BIT on all lanes, busy = 0, underrun = 1 for one cycle, go IDLE.
//   A load accepted on the same edge as a frame end cannot start that frame, because ready was low if hold
//     was full. The new word is simply buffered.
//   Frame start and a load acceptance on the same edge: hold is both drained and refilled in that edge is
//     impossible (ready = 0 while full). After draining, ready rises the next cycle, so the upstream sees
//     one idle ready cycle per frame. Frame output is still gap-free for WIDTH >= 2.
//   Reset asserted mid-frame: the frame is truncated at once, the buffered word is discarded and all
//     outputs take their reset values. After release, nothing is sent until a new load.
//   All outputs are registered. load_data is sampled only on accept; changes at other times have no effect.
// TESTING
//   1 Reset, WIDTH=16, CH=4, LSB_FIRST=1: load 0x0001_8000_AAAA_5555 ->
//       lane0 sends 1,0,1,0..., lane3 sends 1 then 15x0. Checks: frame_start high on bit 0 only,
//       busy high for 16 cycles, then underrun pulse and IDLE_BIT.
//   2 LSB_FIRST=0, same word -> lane2 sends 1 then 15x0; lane3 sends 15x0 then 1.
//   3 Back-to-back: keep load_valid high with 3 words -> 48 contiguous bits, frame_start at cycles 0/16/32,
//       no underrun until after bit 47, frame_count = 3.
//   4 Hold full: hold load_valid high throughout -> load_ready = 0 from the accept until the shifter takes
//       the word. No word is lost or duplicated (scoreboard compare).
//   5 Reset asserted at bit 7 of a frame with a second word buffered -> next cycle serial_out = IDLE_BIT,
//       load_ready = 1, frame_count = 0. After release, no frame output without a new load.
//   6 Wrap: force 65536 frames (WIDTH=2) -> frame_count reads 0x0000 after the 65536th frame start.

Source files
------------

// File: rtl/hcal_multi_serializer.sv
// hcal_multi_serializer: multi-lane parallel-to-serial converter for the HCAL
// front-end path. A one-word hold buffer sits in front of the shift stage so
// that back-to-back frames leave the block with no idle bit between them.
module hcal_multi_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 4,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [CHANNELS*WIDTH-1:0]    load_data,
  output logic [CHANNELS-1:0]          serial_out,
  output logic                         frame_start,
  output logic                         busy,
  output logic                         underrun,
  output logic [15:0]                  frame_count
);

  // The counter must be able to hold WIDTH, which marks "last bit already sent".
  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam int unsigned   IW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                             state_q;
  logic [CHANNELS-1:0][WIDTH-1:0]     hold_q;
  logic [CHANNELS-1:0][WIDTH-1:0]     word_q;
  logic                               hold_full_q;
  logic [CW-1:0]                      cnt_q;
  logic [CHANNELS-1:0]                serial_q;
  logic                               frame_start_q;
  logic                               busy_q;
  logic                               underrun_q;
  logic [15:0]                        frame_count_q;

  logic                               accept;
  logic                               start_frame;
  logic [IW-1:0]                      bit_idx;
  logic [CHANNELS-1:0]                first_bits;
  logic [CHANNELS-1:0]                next_bits;

  // Ready depends only on the hold flop, never on load_valid.
  assign accept      = load_valid && !hold_full_q;
  // A frame starts from IDLE, or on the frame-end edge when a word is waiting.
  assign start_frame = hold_full_q && ((state_q == S_IDLE) || (cnt_q == LAST));
  // cnt_q is the index of the next bit in transmission order.
  assign bit_idx     = LSB_FIRST ? cnt_q[IW-1:0] : (IW'(WIDTH - 1) - cnt_q[IW-1:0]);

  // Per-lane bit selection: first bit straight from hold, later bits from the frame word.
  always_comb begin
    first_bits = '0;
    next_bits  = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      first_bits[c] = LSB_FIRST ? hold_q[c][0] : hold_q[c][WIDTH-1];
      next_bits[c]  = word_q[c][bit_idx];
    end
  end

  // Hold buffer, frame FSM and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      word_q        <= '0;
      hold_full_q   <= 1'b0;
      cnt_q         <= '0;
      serial_q      <= {CHANNELS{IDLE_BIT}};
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      underrun_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      // accept and start_frame are exclusive: one needs hold empty, the other full.
      if (accept) begin
        hold_q      <= load_data;
        hold_full_q <= 1'b1;
      end
      if (start_frame) begin
        word_q        <= hold_q;
        hold_full_q   <= 1'b0;
        serial_q      <= first_bits;
        frame_start_q <= 1'b1;
        busy_q        <= 1'b1;
        frame_count_q <= frame_count_q + 16'd1;
        cnt_q         <= ONE;
        state_q       <= S_SHIFT;
      end else if (state_q == S_SHIFT) begin
        if (cnt_q != LAST) begin
          serial_q <= next_bits;
          cnt_q    <= cnt_q + ONE;
        end else begin
          // Frame finished with nothing buffered: drop to idle and flag it.
          serial_q   <= {CHANNELS{IDLE_BIT}};
          busy_q     <= 1'b0;
          underrun_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= S_IDLE;
        end
      end
    end
  end

  assign load_ready  = !hold_full_q;
  assign serial_out  = serial_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign underrun    = underrun_q;
  assign frame_count = frame_count_q;

endmodule
